shift_exec_stage: RTL and testbench

- Pipelined RV32I shift execution stage. Decodes the shift amount into the 32-bit one-hot shift vector used by the 32-bit shifter, then performs SLL, SRL or SRA.
- Presents a registered result to writeback using a valid/ready handshake.
- Sits between issue (upstream) and writeback (downstream).
- Two register stages, full throughput of one op per cycle, and backpressure propagates stage by stage.

---
 rtl/rv_shift_pkg.sv | 19 +
 rtl/shamt_onehot_dec.sv | 20 ++
 rtl/shift_exec_stage.sv | 116 +++++++++++
 tb/tb_shift_exec_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_shift_pkg.sv
// ==== rv_shift_pkg: shared op encodings and widths for the shift stage, rev 1.0 ====
`default_nettype none

package rv_shift_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b11;
  localparam logic [1:0] SH_RSV = 2'b10;

  function automatic logic is_reserved(input logic [1:0] op);
    return op == SH_RSV;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shamt_onehot_dec.sv
// ==== shamt_onehot_dec: 5-to-32 one-hot shift-amount decoder, rev 1.0 ====
`default_nettype none

module shamt_onehot_dec
  import rv_shift_pkg::*;
(
  input  logic [4:0]      shamt,
  output logic [XLEN-1:0] shvec
);

  always_comb begin
    shvec = '0;
    for (int i = 0; i < XLEN; i++) begin
      shvec[i] = (shamt == 5'(i));
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_exec_stage.sv
// ==== shift_exec_stage: 2-stage RV32I SLL/SRL/SRA execute stage, valid/ready, rev 1.0 ====
`default_nettype none

module shift_exec_stage #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_data,
  input  logic [4:0]      in_shamt,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [TAGW-1:0] out_tag,
  output logic            out_illegal
);
  import rv_shift_pkg::*;

  logic            s1_valid;
  logic [1:0]      s1_op;
  logic [XLEN-1:0] s1_data;
  logic [XLEN-1:0] s1_shvec;
  logic [TAGW-1:0] s1_tag;

  logic            s2_valid;
  logic [XLEN-1:0] s2_result;
  logic [TAGW-1:0] s2_tag;
  logic            s2_illegal;

  logic [XLEN-1:0] dec_shvec;
  logic [XLEN-1:0] sll_res;
  logic [XLEN-1:0] srl_res;
  logic [XLEN-1:0] sra_res;
  logic [XLEN-1:0] shift_res;
  logic            s2_adv;
  logic            accept;

  shamt_onehot_dec u_dec (
    .shamt (in_shamt),
    .shvec (dec_shvec)
  );

  assign s2_adv   = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~s1_valid | s2_adv;
  // An op offered during flush is dropped even when in_ready is high.
  assign accept   = in_valid & in_ready & ~flush;

  // Each shvec bit selects one fixed-distance shift; the one-hot OR is the mux.
  always_comb begin
    sll_res = '0;
    srl_res = '0;
    sra_res = '0;
    for (int k = 0; k < XLEN; k++) begin
      if (s1_shvec[k]) begin
        sll_res |= s1_data << k;
        srl_res |= s1_data >> k;
        sra_res |= XLEN'($signed(s1_data) >>> k);
      end
    end
    case (s1_op)
      SH_SLL:  shift_res = sll_res;
      SH_SRL:  shift_res = srl_res;
      SH_SRA:  shift_res = sra_res;
      default: shift_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_op      <= '0;
      s1_data    <= '0;
      s1_shvec   <= '0;
      s1_tag     <= '0;
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_tag     <= '0;
      s2_illegal <= 1'b0;
    end else begin
      if (accept) begin
        s1_op    <= in_op;
        s1_data  <= in_data;
        s1_shvec <= dec_shvec;
        s1_tag   <= in_tag;
      end
      if (s2_adv) begin
        s2_result  <= shift_res;
        s2_tag     <= s1_tag;
        s2_illegal <= is_reserved(s1_op);
      end
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (accept)      s1_valid <= 1'b1;
        else if (s2_adv) s1_valid <= 1'b0;
        if (s2_adv)         s2_valid <= 1'b1;
        else if (out_ready) s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = s2_valid;
  assign out_result  = s2_result;
  assign out_tag     = s2_tag;
  assign out_illegal = s2_illegal;

endmodule

`default_nettype wire

// File: tb/tb_shift_exec_stage.sv
// ==== tb_shift_exec_stage: scoreboard bench for shift_exec_stage, rev 1.0 ====
`default_nettype none

module tb_shift_exec_stage;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_illegal;

  exp_t sb[$];
  exp_t cur_exp = '0;
  int   tests = 0;
  int   fails = 0;
  int   n_out = 0;
  int   stalls = 0;
  int   base;

  shift_exec_stage #(.XLEN(32), .TAGW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor/scoreboard: pop on output transfer, drop in-flight on flush/reset, push on accept.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got tag %0d result %h, expected no output", out_tag, out_result);
        end else begin
          check("out_result", out_result, sb[0].res);
          check("out_tag", 32'(out_tag), 32'(sb[0].tag));
          check("out_illegal", 32'(out_illegal), 32'(sb[0].ill));
          void'(sb.pop_front());
        end
      end
    end
    if (rst || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(cur_exp);
  end

  // Called at posedge+1; returns at posedge+1 after the capture edge.
  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                      input logic [4:0] tag, input logic [31:0] res, input logic ill);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh; in_tag = tag;
    cur_exp = {res, tag, ill};
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk); #1;
      if (!acc) begin n++; stalls++; end
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: tag %0d not accepted after %0d cycles, expected acceptance", tag, n);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_out_valid"},   32'(out_valid),   32'd0);
    check({pfx, "_out_result"},  out_result,       32'd0);
    check({pfx, "_out_tag"},     32'(out_tag),     32'd0);
    check({pfx, "_out_illegal"}, 32'(out_illegal), 32'd0);
    check({pfx, "_in_ready"},    32'(in_ready),    32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // Latency: out_valid low after the capture edge, high after the next.
    out_ready = 1'b1;
    send(2'b00, 32'h0000_0001, 5'd31, 5'd3, 32'h8000_0000, 1'b0);
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge2_valid", 32'(out_valid), 32'd1);
    idle(2);

    // Back-to-back directed vectors, no stalls expected.
    base = stalls;
    send(2'b11, 32'h8000_0000, 5'd4,  5'd4,  32'hF800_0000, 1'b0);
    send(2'b01, 32'h8000_0000, 5'd4,  5'd5,  32'h0800_0000, 1'b0);
    send(2'b11, 32'h7FFF_FFFF, 5'd31, 5'd6,  32'h0000_0000, 1'b0);
    send(2'b00, 32'hDEAD_BEEF, 5'd0,  5'd7,  32'hDEAD_BEEF, 1'b0);
    send(2'b01, 32'hDEAD_BEEF, 5'd0,  5'd8,  32'hDEAD_BEEF, 1'b0);
    send(2'b11, 32'hDEAD_BEEF, 5'd0,  5'd9,  32'hDEAD_BEEF, 1'b0);
    send(2'b10, 32'hFFFF_FFFF, 5'd3,  5'd10, 32'h0000_0000, 1'b1);
    send(2'b00, 32'h1234_5678, 5'd8,  5'd11, 32'h3456_7800, 1'b0);
    send(2'b01, 32'h8000_0001, 5'd1,  5'd12, 32'h4000_0000, 1'b0);
    idle(3);
    check("b2b_no_stall", 32'(stalls - base), 32'd0);
    check("b2b_drained", 32'(sb.size()), 32'd0);

    // Backpressure: two ops held, third waits, outputs stable while stalled.
    out_ready = 1'b0;
    send(2'b00, 32'hDEAD_BEEF, 5'd4,  5'd1, 32'hEADB_EEF0, 1'b0);
    send(2'b01, 32'hDEAD_BEEF, 5'd16, 5'd2, 32'h0000_DEAD, 1'b0);
    in_valid = 1'b1; in_op = 2'b11; in_data = 32'hDEAD_BEEF; in_shamt = 5'd8; in_tag = 5'd3;
    cur_exp = {32'hFFDE_ADBE, 5'd3, 1'b0};
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_result", out_result, 32'hEADB_EEF0);
      check("bp_hold_tag", 32'(out_tag), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    idle(4);
    check("bp_drained", 32'(sb.size()), 32'd0);

    // Flush with two in flight plus a new op: nothing ever emerges.
    out_ready = 1'b0;
    send(2'b00, 32'h0000_00FF, 5'd2, 5'd11, 32'h0000_03FC, 1'b0);
    send(2'b01, 32'h0000_00FF, 5'd2, 5'd12, 32'h0000_003F, 1'b0);
    base = n_out;
    in_valid = 1'b1; in_op = 2'b00; in_data = 32'h1; in_shamt = 5'd1; in_tag = 5'd13;
    cur_exp = {32'h2, 5'd13, 1'b0};
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    idle(5);
    check("flush_no_outputs", 32'(n_out - base), 32'd0);

    // Flush during an output transfer: that one completes, the other is lost.
    out_ready = 1'b0;
    send(2'b00, 32'h0000_0003, 5'd1, 5'd14, 32'h0000_0006, 1'b0);
    send(2'b01, 32'h0000_00F0, 5'd4, 5'd15, 32'h0000_000F, 1'b0);
    base = n_out;
    out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flushxfer_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flushxfer_after_valid", 32'(out_valid), 32'd0);
    idle(4);
    check("flushxfer_count", 32'(n_out - base), 32'd1);

    // Reset while full and stalled.
    out_ready = 1'b0;
    send(2'b00, 32'hFFFF_FFFF, 5'd0, 5'd20, 32'hFFFF_FFFF, 1'b0);
    send(2'b10, 32'hFFFF_FFFF, 5'd0, 5'd21, 32'h0000_0000, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("midreset");
    out_ready = 1'b1;
    send(2'b11, 32'h8000_0000, 5'd31, 5'd22, 32'hFFFF_FFFF, 1'b0);
    check("post_reset_lat1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("post_reset_lat2", 32'(out_valid), 32'd1);
    idle(3);

    check("final_drained", 32'(sb.size()), 32'd0);
    check("total_outputs", 32'(n_out), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
